// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
//
// Serialises one DATA_BITS-wide word per accepted start strobe onto an idle-high line:
// start bit (0), data bits LSB first, optional even-parity bit, one stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles.
//
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit (>= 2)
//   DATA_BITS     data bits per frame (5..8)
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_start  send request, sampled only while idle
//   tx_data   word to send, captured on the accepting edge
//   tx_out    serial line (registered, idle high)
//   tx_busy   frame in progress (registered)
//   tx_done   one-cycle pulse on frame completion (registered)
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd4,
`endif
    StStop   = 3'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [BaudW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   baud_last;
`ifdef UART_TX_PARITY_EN
  // Parity is taken at acceptance because the shift register is consumed during DATA.
  logic                   parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      StIdle: begin
        if (tx_start) begin
          state_d = StStart;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so the line changes on the same edge
    // as the state.
    case (state_d)
      StStart:  out_d = 1'b0;
      StData:   out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: out_d = parity_d;
`endif
      default:  out_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_out  = out_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the transmit-side counterpart to the receive path's start-bit detector. Accepts a parallel byte on a single-cycle start strobe and serialises it onto an idle-high line as one start bit (0), DATA_BITS data bits LSB first, an optional even-parity bit, and one stop bit (1). Sits between the host-side byte source and the `tx_out` pad. Frames are timed by an internal baud counter.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit; legal minimum 2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tx_start` input 1: request to send; sampled only when `tx_busy`=0.
- `tx_data` input DATA_BITS: byte to send; captured on the accepting edge.
- `tx_out` output 1: serial line; idle high.
- `tx_busy` output 1: high from the cycle after acceptance until the frame completes.
- `tx_done` output 1: one-cycle pulse marking frame completion.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only with macro), STOP.
- IDLE: `tx_out`=1 and `tx_busy`=0. `tx_start`=1 latches `tx_data` into the shift register, clears the baud and bit counters, and moves to START.
- START: `tx_out`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `tx_out` = shift register bit 0. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After DATA_BITS bits, go to PARITY if the macro is defined, otherwise STOP.
- STOP: `tx_out`=1 for CLKS_PER_BIT cycles. At the end, return to IDLE and assert `tx_done` for that one cycle.
- Baud counter width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and never exceeds CLKS_PER_BIT-1.
- Bit counter width: $clog2(DATA_BITS+1).
- `tx_start` while `tx_busy`=1 is ignored. No queuing. The latched data is unaffected.
- `tx_data` changes after acceptance have no effect on the frame in progress.
- Back-to-back frames: `tx_start`=1 in the cycle `tx_done`=1 (state IDLE) is accepted. The next start bit follows with no extra idle bit.
- Reset asserted mid-frame: immediately (asynchronously) `tx_out`=1, `tx_busy`=0, `tx_done`=0, state IDLE, counters 0. The partial frame is abandoned.
- Reset values: `tx_out`=1, `tx_busy`=0, `tx_done`=0, shift register 0.

## Timing
- `tx_out`, `tx_busy` and `tx_done` are all registered. No combinational path from inputs to outputs.
- Edge T0: `tx_start` is sampled high in IDLE.
- From cycle T0+1:
  - `tx_busy`=1.
  - `tx_out`=0 for cycles T0+1 .. T0+CLKS_PER_BIT.
- Data bit k occupies cycles T0+1+(k+1)·CLKS_PER_BIT .. T0+(k+2)·CLKS_PER_BIT.
- Frame length F = (DATA_BITS+2)·CLKS_PER_BIT cycles, or (DATA_BITS+3)·CLKS_PER_BIT with parity.
- Cycle T0+F+1: `tx_busy`=0, `tx_done`=1 for one cycle, `tx_out`=1.
- Throughput: one frame per F+1 cycles when `tx_start` is held high continuously.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: a PARITY state follows DATA. `tx_out` = XOR of the latched data bits (even parity) for CLKS_PER_BIT cycles. Frame grows by one bit.
- Undefined: the PARITY state and its logic are not compiled. DATA goes directly to STOP.

## Test plan
- Reset and idle: `rst_n`=0 then 1 with no `tx_start` → `tx_out`=1, `tx_busy`=0, `tx_done`=0 indefinitely.
- Single frame:
  - Stimulus: CLKS_PER_BIT=4, DATA_BITS=8, `tx_data`=0xA5, one-cycle `tx_start`.
  - Line: 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `tx_done` pulses at T0+41.
- Ignored start: during a 0x3C frame, pulse `tx_start` with `tx_data`=0xFF → the line still carries 0x3C, and exactly one `tx_done` is seen.
- Back-to-back:
  - Stimulus: hold `tx_start`=1 with 0x00 then 0xFF, switching `tx_data` on the `tx_done` cycle.
  - Second start bit begins at T0+42.
  - Both frames are bit-exact, with no idle gap.
- Mid-frame reset: assert `rst_n`=0 during data bit 3 → `tx_out`=1 and `tx_busy`=0 in the same cycle. No `tx_done`. The next frame after release is correct.
- Parity (macro defined):
  - 0x07 → parity bit 1.
  - 0x03 → parity bit 0.
  - Frame length 44 cycles at CLKS_PER_BIT=4.
